// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller in front of a CP0 unit.
//
// Raw interrupt lines are synchronised, edge-detected and latched into PEND.
// Sources enabled in MASK and pending become eligible; the lowest eligible
// index is requested from CP0 through a single registered request line.
//
// Ports
//   clk        main clock, rising edge
//   rst_n      asynchronous active-low reset
//   irq_src    raw asynchronous interrupt lines, active high
//   cfg_we     configuration write strobe
//   cfg_addr   register select: 0 MASK, 1 PEND (W1C), 2 STAT (RO), 3 reserved
//   cfg_wdata  write data, bits [N_SRC-1:0] used
//   cfg_rdata  combinational readback of the selected register
//   ir_en      global interrupt enable (shared with CP0)
//   cp0_ir     registered interrupt request to CP0
//   cp0_taken  one-cycle pulse from CP0 when it takes the interrupt
//   eret       CP0 is executing ERET
//   cause      index of the requested / serviced source (0 when idle)
//   busy       high while an interrupt is being serviced
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding; waits for an eligible source
// REQ      | cp0_ir high, cause frozen, waiting for CP0 to take it
// SERVICE  | handler running; waits for ERET

module int_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic             ir_en,
    output logic             cp0_ir,
    input  logic             cp0_taken,
    input  logic             eret,
    output logic [3:0]       cause,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] edge_q,  edge_d;
    logic [1:0]       warm_q,  warm_d;
    logic [N_SRC-1:0] mask_q,  mask_d;
    logic [N_SRC-1:0] pend_q,  pend_d;
    logic             ir_en_q, ir_en_d;
    state_t           state_q, state_d;
    logic [3:0]       cause_q, cause_d;
    logic             cp0_ir_q, cp0_ir_d;
    logic             busy_q,  busy_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] cause_oh;
    logic [N_SRC-1:0] w1c_mask;
    logic [3:0]       prio_idx;
    logic             prio_found;
    logic             take;
    logic             unused_wdata_hi;

    assign unused_wdata_hi = ^cfg_wdata[31:N_SRC];

    // Synchroniser, edge flop and post-reset warm-up.  Edge detection stays
    // disabled until the whole chain holds real samples, so a line that is
    // already high when reset lifts is seen as a level, not an edge.
    always_comb begin
        sync1_d = irq_src;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        warm_d  = (warm_q != 2'd0) ? warm_q - 2'd1 : 2'd0;
        rise    = (warm_q == 2'd0) ? (sync2_q & ~edge_q) : '0;
    end

    assign eligible = pend_q & mask_q;
    assign cause_oh = ONE_HOT0 << cause_q;

    // Lowest index wins.
    always_comb begin
        prio_idx   = 4'd0;
        prio_found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!prio_found && eligible[i]) begin
                prio_idx   = 4'(i);
                prio_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cp0_ir_d = 1'b0;
        busy_d   = 1'b0;
        take     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ir_en_q && prio_found) begin
                    state_d  = ST_REQ;
                    cause_d  = prio_idx;
                    cp0_ir_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (cp0_taken) begin
                    state_d = ST_SERVICE;
                    take    = 1'b1;
                    busy_d  = 1'b1;
                end else if ((eligible & cause_oh) == '0) begin
                    // Withdrawn before CP0 took it; IDLE guarantees a low
                    // cycle on cp0_ir before any new request.
                    state_d = ST_IDLE;
                    cause_d = 4'd0;
                end else begin
                    cp0_ir_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_IDLE;
                    cause_d = 4'd0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = 4'd0;
            end
        endcase
    end

    // Register file: a fresh edge overrides any clear in the same cycle.
    always_comb begin
        w1c_mask = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0;
        pend_d   = (pend_q & ~(w1c_mask | (take ? cause_oh : '0))) | rise;
        mask_d   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[N_SRC-1:0] : mask_q;
        ir_en_d  = ir_en;
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata = {{(32-N_SRC){1'b0}}, mask_q};
            2'd1:    cfg_rdata = {{(32-N_SRC){1'b0}}, pend_q};
            2'd2:    cfg_rdata = {24'd0, cause_q, 1'b0, state_q, busy_q};
            default: cfg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            edge_q   <= '0;
            warm_q   <= 2'd3;
            mask_q   <= '0;
            pend_q   <= '0;
            ir_en_q  <= 1'b0;
            state_q  <= ST_IDLE;
            cause_q  <= 4'd0;
            cp0_ir_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            warm_q   <= warm_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            ir_en_q  <= ir_en_d;
            state_q  <= state_d;
            cause_q  <= cause_d;
            cp0_ir_q <= cp0_ir_d;
            busy_q   <= busy_d;
        end
    end

    assign cp0_ir = cp0_ir_q;
    assign cause  = cause_q;
    assign busy   = busy_q;

endmodule
